// File: rtl/sync_filter_edge_pkg.sv
// sync_filter_edge_pkg: shared helpers for the input conditioner
package sync_filter_edge_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int counter_width(input int f);
    return clog2(f) < 1 ? 1 : clog2(f);
  endfunction
endpackage

// File: rtl/sync_filter_channel.sv
// sync_filter_channel: one-bit synchroniser, stability filter and edge pulses
module sync_filter_channel
  import sync_filter_edge_pkg::*;
#(
  parameter int   p_DEPTH     = 3,
  parameter int   p_FILTER    = 4,
  parameter logic p_RESET_BIT = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_input,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = counter_width(p_FILTER);
  logic [p_DEPTH-1:0] sync;
  logic [CW-1:0]      cnt;
  logic               s;
  logic               flip;
  assign s = sync[p_DEPTH-1];
  // Level flips once the synchronised sample has differed for p_FILTER edges in a row
  always_comb flip = (s != o_level) && (cnt == CW'(p_FILTER - 1));
  // Synchroniser chain; only stage 0 ever sees the raw pin
  always_ff @(posedge i_clk)
    sync <= i_reset ? {p_DEPTH{p_RESET_BIT}} : {sync[p_DEPTH-2:0], i_input};
  // Filter counter, filtered level and registered edge pulses
  always_ff @(posedge i_clk)
    if (i_reset) begin
      cnt     <= '0;
      o_level <= p_RESET_BIT;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
    end else begin
      cnt     <= (s == o_level || flip) ? '0 : cnt + CW'(1);
      o_level <= flip ? s : o_level;
      o_rise  <= flip & s;
      o_fall  <= flip & ~s;
    end
endmodule

// File: rtl/sync_filter_edge.sv
// sync_filter_edge: multi-channel synchronise, glitch-filter and edge-detect
module sync_filter_edge
  import sync_filter_edge_pkg::*;
#(
  parameter int                 p_WIDTH       = 3,
  parameter int                 p_DEPTH       = 3,
  parameter int                 p_FILTER      = 4,
  parameter logic [p_WIDTH-1:0] p_RESET_VALUE = '0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [p_WIDTH-1:0] iv_input,
  output logic [p_WIDTH-1:0] ov_level,
  output logic [p_WIDTH-1:0] ov_rise,
  output logic [p_WIDTH-1:0] ov_fall
);
  for (genvar i = 0; i < p_WIDTH; i++) begin : g_ch
    sync_filter_channel #(
      .p_DEPTH    (p_DEPTH),
      .p_FILTER   (p_FILTER),
      .p_RESET_BIT(p_RESET_VALUE[i])
    ) u_ch (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_input(iv_input[i]),
      .o_level(ov_level[i]),
      .o_rise (ov_rise[i]),
      .o_fall (ov_fall[i])
    );
  end
endmodule

// File: tb/tb_sync_filter_edge.sv
// tb_sync_filter_edge: random and directed checks against a window-based reference
module tb_sync_filter_edge;
  localparam int W = 3;
  localparam int D = 3;
  localparam int F = 4;
  localparam logic [W-1:0] RV2 = 3'b101;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] inp = '0;
  logic [W-1:0] inp2 = RV2;
  logic [W-1:0] level, rise, fall, level2, rise2, fall2;
  int tests = 0;
  int fails = 0;
  logic [W-1:0] pipe[$];
  logic [W-1:0] win[$];
  logic [W-1:0] m_level, m_rise, m_fall;

  always #5 clk = ~clk;

  sync_filter_edge #(.p_WIDTH(W), .p_DEPTH(D), .p_FILTER(F), .p_RESET_VALUE('0)) dut (
    .i_clk(clk), .i_reset(rst), .iv_input(inp),
    .ov_level(level), .ov_rise(rise), .ov_fall(fall)
  );

  sync_filter_edge #(.p_WIDTH(W), .p_DEPTH(D), .p_FILTER(F), .p_RESET_VALUE(RV2)) dut2 (
    .i_clk(clk), .i_reset(rst), .iv_input(inp2),
    .ov_level(level2), .ov_rise(rise2), .ov_fall(fall2)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: s seen by the filter is the input from D edges ago; a channel flips
  // when the last F seen samples all differ from its current level.
  task automatic model_edge();
    logic [W-1:0] seen;
    logic all_diff;
    if (rst) begin
      pipe.delete();
      for (int k = 0; k < D; k++) pipe.push_back('0);
      win.delete();
      m_level = '0;
      m_rise = '0;
      m_fall = '0;
    end else begin
      seen = pipe.pop_front();
      pipe.push_back(inp);
      win.push_back(seen);
      if (win.size() > F) void'(win.pop_front());
      m_rise = '0;
      m_fall = '0;
      if (win.size() == F)
        for (int i = 0; i < W; i++) begin
          all_diff = 1'b1;
          foreach (win[k]) if (win[k][i] == m_level[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_level[i] = ~m_level[i];
            m_rise[i] = m_level[i];
            m_fall[i] = ~m_level[i];
          end
        end
    end
  endtask

  task automatic tick(input logic [W-1:0] v, input logic r);
    @(negedge clk);
    inp = v;
    rst = r;
    @(posedge clk);
    model_edge();
    #1;
    check("level", level, m_level);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("level_rv", level2, RV2);
    check("rise_rv", rise2, '0);
    check("fall_rv", fall2, '0);
  endtask

  initial begin
    logic [W-1:0] v;
    int hold;
    tick(3'b111, 1'b1);
    tick(3'b111, 1'b1);
    check("reset_level", level, 3'b000);
    tick(3'b000, 1'b0);
    check("release_rise", rise, 3'b000);
    for (int n = 0; n < 8; n++) tick(3'b000, 1'b0);
    for (int n = 1; n <= 7; n++) begin
      tick(3'b001, 1'b0);
      if (n == 6) check("step_pre", level, 3'b000);
    end
    check("step_level", level, 3'b001);
    check("step_rise", rise, 3'b001);
    tick(3'b001, 1'b0);
    check("step_rise_end", rise, 3'b000);
    for (int n = 0; n < 3; n++) tick(3'b011, 1'b0);
    for (int n = 0; n < 8; n++) begin
      tick(3'b001, 1'b0);
      check("glitch3_level", level, 3'b001);
    end
    for (int n = 0; n < 4; n++) tick(3'b011, 1'b0);
    for (int n = 0; n < 10; n++) tick(3'b001, 1'b0);
    for (int n = 1; n <= 7; n++) tick(3'b110, 1'b0);
    check("simul_level", level, 3'b110);
    check("simul_rise", rise, 3'b110);
    check("simul_fall", fall, 3'b001);
    for (int n = 0; n < 10; n++) tick(3'b000, 1'b0);
    for (int n = 0; n < 5; n++) tick(3'b111, 1'b0);
    tick(3'b111, 1'b1);
    check("midrst_level", level, 3'b000);
    check("midrst_rise", rise, 3'b000);
    for (int n = 1; n <= 7; n++) begin
      tick(3'b111, 1'b0);
      if (n == 6) check("midrst_pre", level, 3'b000);
    end
    check("midrst_level_after", level, 3'b111);
    check("midrst_rise_after", rise, 3'b111);
    for (int n = 0; n < 300; n++) begin
      v = W'($urandom);
      hold = $urandom_range(1, 6);
      for (int h = 0; h < hold; h++) tick(v, ($urandom_range(0, 79) == 0));
    end
    for (int n = 0; n < 10; n++) tick(v, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
